// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end. Owns the architectural PC, issues
//             in-order word fetches, collects in-order responses into a fetch
//             queue and hands PC-tagged instructions to decode. Redirects flush
//             queued and in-flight fetches.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int              AW   = $clog2(DEPTH);
   localparam int              PW   = AW + 1;
   localparam logic [PW-1:0]   FULL = PW'(DEPTH);
   localparam logic [PW-1:0]   ONE  = PW'(1);

   // Architectural PC and queue bookkeeping
   logic [31:0]      pc_q, pc_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [PW-1:0]    fill_q, fill_d;
   logic [PW-1:0]    drop_q, drop_d;
   logic [DEPTH-1:0] filled_q, filled_d;

   // Entry payload storage (no reset needed: guarded by the filled flags)
   logic [31:0]      ent_pc_q   [DEPTH];
   logic [31:0]      ent_inst_q [DEPTH];

   logic [AW-1:0]    w_head_idx;
   logic [AW-1:0]    w_tail_idx;
   logic [AW-1:0]    w_fill_idx;
   logic [PW-1:0]    w_count;
   logic [PW-1:0]    w_unfilled;
   logic             w_out_valid;
   logic             w_pop;
   logic             w_req_valid;
   logic             w_push;
   logic             w_rsp_consume;
   logic             w_fill;
   logic             w_drop;
   logic             w_unused;

   assign w_head_idx  = head_q[AW-1:0];
   assign w_tail_idx  = tail_q[AW-1:0];
   assign w_fill_idx  = fill_q[AW-1:0];
   assign w_count     = tail_q - head_q;
   assign w_unfilled  = tail_q - fill_q;

   assign w_out_valid = filled_q[w_head_idx];
   assign w_pop       = w_out_valid & out_ready;

   // A pop frees a slot in the same cycle, so a full queue can still issue
   assign w_req_valid = !rst && !redirect && ((w_count != FULL) || w_pop);
   assign w_push      = w_req_valid & imem_req_ready;

   // Any response that matches an outstanding fetch (stale or live)
   assign w_rsp_consume = imem_rsp_valid && ((drop_q != '0) || (w_unfilled != '0));
   // Live responses land in the oldest unfilled entry; a redirect discards them
   assign w_fill      = !rst && !redirect && imem_rsp_valid &&
                        (drop_q == '0) && (w_unfilled != '0);
   assign w_drop      = imem_rsp_valid && (drop_q != '0);

   // Low PC bits of the redirect target are forced to zero
   assign w_unused    = ^next_pc[1:0];

   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = pc_q;
   assign out_valid      = w_out_valid;
   assign out_pc         = ent_pc_q[w_head_idx];
   assign out_inst       = ent_inst_q[w_head_idx];

   // Next-state computation for PC, pointers, drop counter and filled flags
   always_comb begin
      pc_d     = pc_q;
      head_d   = head_q;
      tail_d   = tail_q;
      fill_d   = fill_q;
      drop_d   = drop_q;
      filled_d = filled_q;
      if (redirect) begin
         pc_d     = {next_pc[31:2], 2'b00};
         head_d   = tail_q;
         fill_d   = tail_q;
         filled_d = '0;
         // Every unfilled entry is still owed a response that must be thrown
         // away; a response consumed this very cycle settles one of those debts
         drop_d   = drop_q + w_unfilled - (w_rsp_consume ? ONE : '0);
      end else begin
         if (w_push) begin
            pc_d                 = pc_q + 32'd4;
            tail_d               = tail_q + ONE;
            filled_d[w_tail_idx] = 1'b0;
         end
         if (w_pop) begin
            head_d               = head_q + ONE;
            filled_d[w_head_idx] = 1'b0;
         end
         if (w_fill) begin
            fill_d               = fill_q + ONE;
            filled_d[w_fill_idx] = 1'b1;
         end
         if (w_drop) begin
            drop_d = drop_q - ONE;
         end
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
         filled_q <= '0;
      end else begin
         pc_q     <= pc_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         fill_q   <= fill_d;
         drop_q   <= drop_d;
         filled_q <= filled_d;
      end
   end

   // Entry payload writes: PC on reservation, instruction on fill
   always_ff @(posedge clk) begin
      if (w_push) begin
         ent_pc_q[w_tail_idx] <= pc_q;
      end
      if (w_fill) begin
         ent_inst_q[w_fill_idx] <= imem_rsp_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with an in-order
//             variable-latency instruction memory model and an expected
//             instruction scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] next_pc;
   logic        redirect;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_ready;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   logic [31:0] d2_pc;
   logic [31:0] d2_pc_plus4;
   logic        d2_req_valid;
   logic [31:0] d2_req_addr;
   logic        d2_out_valid;
   logic [31:0] d2_out_pc;
   logic [31:0] d2_out_inst;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .next_pc        (next_pc),
      .redirect       (redirect),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst)
   );

   // Second instance only used to observe the reset PC and PC wrap-around
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut2 (
      .clk            (clk),
      .rst            (rst),
      .pc             (d2_pc),
      .pc_plus4       (d2_pc_plus4),
      .next_pc        (next_pc),
      .redirect       (redirect),
      .imem_req_valid (d2_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (d2_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (d2_out_valid),
      .out_ready      (out_ready),
      .out_pc         (d2_out_pc),
      .out_inst       (d2_out_inst)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          lat    = 1;
   int          n_req  = 0;
   int          n_pop  = 0;
   int          waited = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] sb_pc   [$];
   logic [31:0] sb_inst [$];
   logic [31:0] mem_addr [$];
   int          mem_due  [$];
   logic        hs_pend;
   logic [31:0] hs_addr;
   logic        rst_seen;

   function automatic logic [31:0] f_inst(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample handshakes mid-cycle, then advance the memory model
   task automatic tick();
      @(negedge clk);
      hs_pend  = 1'b0;
      rst_seen = rst;
      if (rst) begin
         sb_pc.delete();
         sb_inst.delete();
         mem_addr.delete();
         mem_due.delete();
         exp_pc = 32'h0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            check("req_pc", pc, exp_pc);
            n_req++;
            sb_pc.push_back(exp_pc);
            sb_inst.push_back(f_inst(exp_pc));
            hs_pend = 1'b1;
            hs_addr = imem_req_addr;
            exp_pc  = exp_pc + 32'd4;
         end
         if (out_valid) begin
            if (sb_pc.size() == 0) begin
               check("out_valid_unexpected", {31'b0, out_valid}, 32'h0);
            end else begin
               check("out_pc", out_pc, sb_pc[0]);
               check("out_inst", out_inst, sb_inst[0]);
               if (out_ready) begin
                  void'(sb_pc.pop_front());
                  void'(sb_inst.pop_front());
                  n_pop++;
               end
            end
         end
         if (redirect) begin
            check("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'h0);
            sb_pc.delete();
            sb_inst.delete();
            exp_pc = next_pc & 32'hFFFF_FFFC;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_seen && hs_pend) begin
         mem_addr.push_back(hs_addr);
         mem_due.push_back(cyc + lat - 1);
      end
      if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = f_inst(mem_addr[0]);
         void'(mem_addr.pop_front());
         void'(mem_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   initial begin
      rst            = 1'b1;
      redirect       = 1'b0;
      next_pc        = 32'h0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      out_ready      = 1'b1;
      lat            = 1;

      // ---------------- reset state ----------------
      tick();
      tick();
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_pc_d2", d2_pc, 32'hFFFF_FFF8);
      check("rst_pc_plus4_d2", d2_pc_plus4, 32'hFFFF_FFFC);

      // ---------------- free run, 1-cycle memory ----------------
      rst = 1'b0;
      #1;
      check("c0_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("c0_req_addr", imem_req_addr, 32'h0);
      check("c0_out_valid", {31'b0, out_valid}, 32'h0);
      tick(); #1;
      check("c1_out_valid", {31'b0, out_valid}, 32'h0);
      check("c1_pc_d2", d2_pc, 32'hFFFF_FFFC);
      check("c1_pc_plus4_d2_wrap", d2_pc_plus4, 32'h0);
      tick(); #1;
      check("c2_out_valid", {31'b0, out_valid}, 32'h1);
      check("c2_out_pc", out_pc, 32'h0);
      check("c2_pc_d2_wrap", d2_pc, 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         check("stream_out_valid", {31'b0, out_valid}, 32'h1);
      end

      // ---------------- back-pressure ----------------
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      out_ready = 1'b0;
      n_req     = 0;
      for (int i = 0; i < 10; i++) tick();
      #1;
      check("stall_n_req", 32'(n_req), 32'd4);
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("stall_out_pc", out_pc, 32'h0);
      check("stall_out_inst", out_inst, f_inst(32'h0));
      out_ready = 1'b1;
      #1;
      check("release_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("release_req_addr", imem_req_addr, 32'h10);
      n_pop = 0;
      for (int i = 0; i < 4; i++) tick();
      #1;
      check("drain_n_pop", 32'(n_pop), 32'd4);
      check("resume_out_pc", out_pc, 32'h10);

      // ---------------- 3-cycle memory, redirect with two in flight ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lat = 3;
      tick();                         // request 0x0
      tick();                         // request 0x4
      redirect = 1'b1;
      next_pc  = 32'h0000_0103;
      #1;
      check("redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      check("redir_pc", pc, 32'h100);
      check("redir_req_addr", imem_req_addr, 32'h100);
      check("redir_req_valid_next", {31'b0, imem_req_valid}, 32'h1);
      waited = 0;
      while (!out_valid && waited < 12) begin
         tick();
         waited++;
      end
      #1;
      check("redir_first_out_valid", {31'b0, out_valid}, 32'h1);
      check("redir_first_out_pc", out_pc, 32'h100);
      check("redir_latency", 32'(waited), 32'd4);
      for (int i = 0; i < 6; i++) tick();

      // ---------------- redirect colliding with response and pop ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lat = 1;
      for (int i = 0; i < 6; i++) tick();
      redirect = 1'b1;
      next_pc  = 32'hFFFF_FFF9;
      #1;
      check("coll_out_valid", {31'b0, out_valid}, 32'h1);
      check("coll_rsp_valid", {31'b0, imem_rsp_valid}, 32'h1);
      check("coll_req_valid", {31'b0, imem_req_valid}, 32'h0);
      n_pop = 0;
      tick();
      redirect = 1'b0;
      #1;
      check("coll_pop_once", 32'(n_pop), 32'd1);
      check("coll_pc", pc, 32'hFFFF_FFF8);
      check("coll_pc_plus4", pc_plus4, 32'hFFFF_FFFC);
      check("coll_n1_out_valid", {31'b0, out_valid}, 32'h0);
      tick(); #1;
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      check("coll_n2_out_valid", {31'b0, out_valid}, 32'h0);
      tick(); #1;
      check("coll_n3_out_valid", {31'b0, out_valid}, 32'h1);
      check("coll_n3_out_pc", out_pc, 32'hFFFF_FFF8);
      tick(); #1;
      check("wrap_out_pc_1", out_pc, 32'hFFFF_FFFC);
      tick(); #1;
      check("wrap_out_pc_2", out_pc, 32'h0);
      for (int i = 0; i < 3; i++) tick();

      // ---------------- reset with full queue and a pending drop ----------------
      rst = 1'b1;
      tick();
      rst            = 1'b0;
      lat            = 8;
      out_ready      = 1'b0;
      imem_req_ready = 1'b1;
      tick();                         // one slow request outstanding
      redirect = 1'b1;
      next_pc  = 32'h0000_0200;
      tick();                         // leaves one response to drop
      redirect = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #1;
      check("full_req_valid", {31'b0, imem_req_valid}, 32'h0);
      rst = 1'b1;
      tick();
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("mid_rst_pc", pc, 32'h0);
      tick();
      rst       = 1'b0;
      lat       = 1;
      out_ready = 1'b1;
      #1;
      check("restart_req_addr", imem_req_addr, 32'h0);
      tick();
      tick(); #1;
      check("restart_out_valid", {31'b0, out_valid}, 32'h1);
      check("restart_out_pc", out_pc, 32'h0);
      check("restart_out_inst", out_inst, f_inst(32'h0));
      for (int i = 0; i < 6; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
